// File: rtl/div_unit_pkg.sv
// Shared execute-stage defines: HI/LO op codes, divider state encodings
// and the control-side handshake constants.
package div_unit_pkg;

  localparam logic [5:0] OP_MFHI  = 6'h10;
  localparam logic [5:0] OP_MTHI  = 6'h11;
  localparam logic [5:0] OP_MULT  = 6'h18;
  localparam logic [5:0] OP_MULTU = 6'h19;
  localparam logic [5:0] OP_DIV   = 6'h1A;
  localparam logic [5:0] OP_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    DIV_IDLE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_t;

  localparam logic DIV_READY     = 1'b1;
  localparam logic DIV_NOT_READY = 1'b0;
  localparam logic DIV_START     = 1'b1;
  localparam logic DIV_STOP      = 1'b0;

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU; one quotient bit per cycle,
// result delivered as {remainder, quotient} for the HI/LO write path.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  signed_i,
  input  logic                  annul_i,
  input  logic [DATA_W-1:0]     opa_i,
  input  logic [DATA_W-1:0]     opb_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  busy_o
);

  div_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] dvd;
  logic [DATA_W-1:0] dsr;
  logic [DATA_W-1:0] rem;
  logic              sgn;
  logic              sign_a;
  logic              sign_b;

  logic [DATA_W-1:0] mag_a;
  logic [DATA_W-1:0] mag_b;
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   diff;
  logic              ge;
  logic [DATA_W-1:0] rem_nxt;
  logic [DATA_W-1:0] quo_nxt;
  logic [DATA_W-1:0] rem_fix;
  logic [DATA_W-1:0] quo_fix;

  // Operand magnitudes, one trial-subtract step, and final sign fix-up
  always_comb begin
    mag_a   = (signed_i && opa_i[DATA_W-1]) ? -opa_i : opa_i;
    mag_b   = (signed_i && opb_i[DATA_W-1]) ? -opb_i : opb_i;
    shifted = {rem, dvd[DATA_W-1]};
    diff    = shifted - {1'b0, dsr};
    ge      = ~diff[DATA_W];
    rem_nxt = ge ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
    quo_nxt = {dvd[DATA_W-2:0], ge};
    quo_fix = (sgn && (sign_a ^ sign_b)) ? -quo_nxt : quo_nxt;
    rem_fix = (sgn && sign_a) ? -rem_nxt : rem_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= DIV_IDLE;
      cnt      <= '0;
      dvd      <= '0;
      dsr      <= '0;
      rem      <= '0;
      sgn      <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      result_o <= '0;
      ready_o  <= DIV_NOT_READY;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start_i == DIV_START && !annul_i) begin
            if (opb_i == '0) begin
              state <= DIV_BYZERO;
            end else begin
              state  <= DIV_ON;
              dvd    <= mag_a;
              dsr    <= mag_b;
              rem    <= '0;
              cnt    <= '0;
              sgn    <= signed_i;
              sign_a <= opa_i[DATA_W-1];
              sign_b <= opb_i[DATA_W-1];
            end
          end
        end
        // Zero divisor completes with a zero result instead of trapping
        DIV_BYZERO: begin
          if (annul_i) begin
            state <= DIV_IDLE;
          end else begin
            state    <= DIV_END;
            result_o <= '0;
            ready_o  <= DIV_READY;
          end
        end
        DIV_ON: begin
          if (annul_i) begin
            state <= DIV_IDLE;
          end else begin
            rem <= rem_nxt;
            dvd <= quo_nxt;
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(DATA_W - 1)) begin
              state    <= DIV_END;
              result_o <= {rem_fix, quo_fix};
              ready_o  <= DIV_READY;
            end
          end
        end
        DIV_END: begin
          if (start_i == DIV_STOP) begin
            state    <= DIV_IDLE;
            result_o <= '0;
            ready_o  <= DIV_NOT_READY;
          end
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

  assign busy_o = (state == DIV_BYZERO) || (state == DIV_ON);

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: arithmetic model for {rem, quo}, latency,
// busy window, annul and asynchronous reset behaviour.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sgn;
  logic        annul;
  logic [31:0] opa;
  logic [31:0] opb;
  logic [63:0] result;
  logic        ready;
  logic        busy;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_model = '0;
  logic        no_ready  = 1'b0;

  div_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start),
    .signed_i (sgn),
    .annul_i  (annul),
    .opa_i    (opa),
    .opb_i    (opb),
    .result_o (result),
    .ready_o  (ready),
    .busy_o   (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", nm, act, exp);
    end
  endtask

  // Truncating division in 64-bit arithmetic; remainder follows the dividend
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint la, lb, q, r;
    if (b == 32'h0) return 64'h0;
    if (s) begin
      la = longint'($signed(a));
      lb = longint'($signed(b));
    end else begin
      la = longint'({32'h0, a});
      lb = longint'({32'h0, b});
    end
    q = la / lb;
    r = la % lb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Continuous compare: any asserted ready must carry the modelled result
  always @(negedge clk) begin
    if (!rst && ready) begin
      check("stream_result", result, exp_model);
      check("stream_busy_with_ready", 64'(busy), 64'h0);
      if (no_ready) check("stream_ready_after_annul", 64'(ready), 64'h0);
    end
  end

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [63:0] lit, input string nm, input int hold);
    int n;
    int busy_cnt;
    int want;
    exp_model = model(a, b, s);
    check({nm, "_model"}, exp_model, lit);
    opa   = a;
    opb   = b;
    sgn   = s;
    start = 1'b1;
    tick();
    // Operands must be ignored once the request has been accepted
    opa = ~a;
    opb = ~b;
    sgn = ~s;
    busy_cnt = busy ? 1 : 0;
    n = 0;
    while (!ready && n < 100) begin
      tick();
      n++;
      if (busy) busy_cnt++;
    end
    want = (b == 32'h0) ? 1 : 32;
    check({nm, "_latency"}, 64'(n), 64'(want));
    check({nm, "_busy_cycles"}, 64'(busy_cnt), 64'(want));
    check({nm, "_result"}, result, lit);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({nm, "_held_ready"}, 64'(ready), 64'h1);
      check({nm, "_held_result"}, result, lit);
    end
    start = 1'b0;
    tick();
    check({nm, "_drop_ready"}, 64'(ready), 64'h0);
    check({nm, "_drop_result"}, result, 64'h0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    sgn   = 1'b0;
    annul = 1'b0;
    opa   = '0;
    opb   = '0;
    repeat (3) tick();
    check("reset_result", result, 64'h0);
    check("reset_ready", 64'(ready), 64'h0);
    check("reset_busy", 64'(busy), 64'h0);
    rst = 1'b0;
    tick();

    run_div(32'd100,       32'd7,         1'b0, 64'h00000002_0000000E, "divu_100_7", 2);
    run_div(32'hFFFFFFF9,  32'd2,         1'b1, 64'hFFFFFFFF_FFFFFFFD, "div_m7_2", 0);
    run_div(32'd7,         32'hFFFFFFFE,  1'b1, 64'h00000001_FFFFFFFD, "div_7_m2", 0);
    run_div(32'h80000000,  32'hFFFFFFFF,  1'b1, 64'h00000000_80000000, "div_min_m1", 0);
    run_div(32'hFFFFFFFF,  32'd1,         1'b0, 64'h00000000_FFFFFFFF, "divu_max_1", 0);
    run_div(32'hFFFFFF9C,  32'hFFFFFFF9,  1'b1, 64'hFFFFFFFE_0000000E, "div_m100_m7", 0);
    run_div(32'hFFFFFFFF,  32'h00010000,  1'b0, 64'h0000FFFF_0000FFFF, "divu_max_64k", 0);
    run_div(32'd5,         32'd0,         1'b0, 64'h0, "divu_by_zero", 1);

    // Annul mid-iteration, then confirm annul also blocks acceptance in IDLE
    no_ready = 1'b1;
    opa   = 32'd1000;
    opb   = 32'd3;
    sgn   = 1'b0;
    start = 1'b1;
    tick();
    repeat (10) tick();
    check("annul_busy_before", 64'(busy), 64'h1);
    annul = 1'b1;
    tick();
    check("annul_busy_after", 64'(busy), 64'h0);
    check("annul_ready_after", 64'(ready), 64'h0);
    tick();
    check("annul_blocks_start", 64'(busy), 64'h0);
    annul    = 1'b0;
    no_ready = 1'b0;
    run_div(32'd9, 32'd4, 1'b0, 64'h00000001_00000002, "after_annul", 0);

    // Asynchronous reset while holding a result
    exp_model = model(32'hFFFFFFFF, 32'd1, 1'b0);
    opa   = 32'hFFFFFFFF;
    opb   = 32'd1;
    start = 1'b1;
    repeat (33) tick();
    check("end_ready_before_rst", 64'(ready), 64'h1);
    #2 rst = 1'b1;
    #1;
    check("rst_end_result", result, 64'h0);
    check("rst_end_ready", 64'(ready), 64'h0);
    start = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // Asynchronous reset mid-iteration
    opa   = 32'd1000;
    opb   = 32'd3;
    start = 1'b1;
    repeat (6) tick();
    check("on_busy_before_rst", 64'(busy), 64'h1);
    #2 rst = 1'b1;
    #1;
    check("rst_on_busy", 64'(busy), 64'h0);
    check("rst_on_ready", 64'(ready), 64'h0);
    check("rst_on_result", result, 64'h0);
    start = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    run_div(32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, "after_rst", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
